// File: rtl/stc_output_drain.sv
// rtl/stc_output_drain.sv - two-slot ping-pong result buffer draining one PE row per cycle
module stc_output_drain #(
  parameter int N       = 16,
  parameter int N_PE    = 4,
  parameter int DW_DATA = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_PE*N*DW_DATA-1:0]     in_acc,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          relu_en,
  output logic [N*DW_DATA-1:0]          out_data,
  output logic [$clog2(N_PE)-1:0]       out_row,
  output logic                          out_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [15:0]                   tiles_done
);

  localparam int RW     = $clog2(N_PE);
  localparam int ROW_W  = N * DW_DATA;
  localparam int TILE_W = N_PE * ROW_W;
  localparam logic [RW-1:0] LAST_ROW = RW'(N_PE - 1);

  logic [TILE_W-1:0] slot_q [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic [RW-1:0]     row;

  logic [TILE_W-1:0] capt_data;
  logic [ROW_W-1:0]  sel_row;
  logic              capture;
  logic              handshake;
  logic              complete;

  always_comb begin
    capt_data = in_acc;
    for (int k = 0; k < N_PE * N; k++) begin
      if (relu_en && in_acc[k*DW_DATA + DW_DATA - 1]) begin
        capt_data[k*DW_DATA +: DW_DATA] = '0;
      end
    end
  end

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign capture   = in_valid && in_ready;
  assign handshake = out_valid && out_ready;
  assign complete  = handshake && (row == LAST_ROW);

  // Slot contents are never reset; an empty buffer masks them through count.
  always_ff @(posedge clk) begin
    if (capture) begin
      slot_q[wr_ptr] <= capt_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= 2'd0;
      row        <= '0;
      tiles_done <= 16'd0;
    end else begin
      if (capture) begin
        wr_ptr <= ~wr_ptr;
      end
      if (handshake) begin
        if (row == LAST_ROW) begin
          row        <= '0;
          rd_ptr     <= ~rd_ptr;
          tiles_done <= tiles_done + 16'd1;
        end else begin
          row <= row + 1'b1;
        end
      end
      case ({capture, complete})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    sel_row = '0;
    for (int i = 0; i < N_PE; i++) begin
      if (row == RW'(i)) begin
        sel_row = slot_q[rd_ptr][i*ROW_W +: ROW_W];
      end
    end
  end

  assign out_data = out_valid ? sel_row : '0;
  assign out_row  = out_valid ? row : '0;
  assign out_last = out_valid && (row == LAST_ROW);

endmodule
